// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one multi-cycle divider among NREQ requesters.
// Build option: define DIV_ARB_ZERO_BYPASS_EN to answer zero divisors locally.
module div_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_quot,
  output logic [WIDTH-1:0]      rsp_rem,
  output logic                  busy,
  output logic [WIDTH-1:0]      div_a,
  output logic [WIDTH-1:0]      div_b,
  output logic                  div_start,
  input  logic [WIDTH-1:0]      div_quot,
  input  logic [WIDTH-1:0]      div_rem,
  input  logic                  div_ready
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] Lsb = NREQ'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StResp} state_e;

  state_e           state_q;
  logic [PtrW-1:0]  ptr_q;
  logic [PtrW-1:0]  gnt_q;
  logic [PtrW-1:0]  gnt_idx;
  logic [PtrW-1:0]  cand;
  logic             gnt_found;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             zero_byp;

  // Search starts one past the last served requester so every valid requester is reached.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = PtrW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == PtrW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef DIV_ARB_ZERO_BYPASS_EN
  assign zero_byp = (sel_b == '0);
`else
  assign zero_byp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= PtrW'(NREQ - 1);
      gnt_q     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      busy      <= 1'b0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      rsp_quot  <= '0;
      rsp_rem   <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      unique case (state_q)
        StIdle: begin
          // The divider has no reset, so a new issue must wait until it reports idle.
          if (gnt_found && (div_ready || zero_byp)) begin
            req_ready <= Lsb << gnt_idx;
            gnt_q     <= gnt_idx;
            busy      <= 1'b1;
            if (zero_byp) begin
              rsp_quot <= '1;
              rsp_rem  <= sel_a;
              state_q  <= StResp;
            end else begin
              div_a     <= sel_a;
              div_b     <= sel_b;
              div_start <= 1'b1;
              state_q   <= StIssue;
            end
          end
        end
        StIssue: begin
          if (!div_ready) begin
            div_start <= 1'b0;
            state_q   <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (div_ready) begin
            rsp_quot <= div_quot;
            rsp_rem  <= div_rem;
            state_q  <= StResp;
          end
        end
        StResp: begin
          rsp_valid <= Lsb << gnt_q;
          ptr_q     <= gnt_q;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));
  a_busy_state:   assert property (@(posedge clk) disable iff (!rst_n)
                                   busy == (state_q != StIdle));

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural multi-cycle divider attached.
module tb_div_arbiter;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned WIDTH  = 4;
  localparam int unsigned DivLat = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_quot;
  logic [WIDTH-1:0]      rsp_rem;
  logic                  busy;
  logic [WIDTH-1:0]      div_a;
  logic [WIDTH-1:0]      div_b;
  logic                  div_start;
  logic [WIDTH-1:0]      div_quot;
  logic [WIDTH-1:0]      div_rem;
  logic                  div_ready;

  div_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_quot  (rsp_quot),
    .rsp_rem   (rsp_rem),
    .busy      (busy),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_start (div_start),
    .div_quot  (div_quot),
    .div_rem   (div_rem),
    .div_ready (div_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Divider model: no reset, busy DivLat cycles after a start seen while idle.
  logic             dv_idle  = 1'b1;
  logic             hold_low = 1'b0;
  int               dv_cnt   = 0;
  logic [WIDTH-1:0] dv_a = '0, dv_b = '0, dv_q = '0, dv_r = '0;

  assign div_ready = dv_idle && !hold_low;
  assign div_quot  = dv_q;
  assign div_rem   = dv_r;

  always @(posedge clk) begin
    if (dv_idle) begin
      if (div_start && div_ready) begin
        dv_idle <= 1'b0;
        dv_cnt  <= DivLat;
        dv_a    <= div_a;
        dv_b    <= div_b;
      end
    end else if (dv_cnt == 1) begin
      dv_idle <= 1'b1;
      dv_q    <= (dv_b == 0) ? {WIDTH{1'b1}} : dv_a / dv_b;
      dv_r    <= (dv_b == 0) ? dv_a : dv_a % dv_b;
    end else begin
      dv_cnt <= dv_cnt - 1;
    end
  end

  // Protocol monitor: one-hot, single-cycle pulses, accept/response bookkeeping.
  int              acc_cnt [NREQ];
  int              rsp_cnt [NREQ];
  int              tot_rsp = 0;
  int              starts  = 0;
  logic [NREQ-1:0] rr_prev = '0;
  logic [NREQ-1:0] rv_prev = '0;
  logic            ds_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        acc_cnt[i] <= 0;
        rsp_cnt[i] <= 0;
      end
    end else begin
      if ((req_ready != '0) || (rsp_valid != '0)) begin
        check_eq("ready_onehot", 32'($onehot0(req_ready)), 1);
        check_eq("rsp_onehot", 32'($onehot0(rsp_valid)), 1);
        check_eq("ready_width", 32'(req_ready & rr_prev), 0);
        check_eq("rsp_width", 32'(rsp_valid & rv_prev), 0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
        if (rsp_valid[i]) rsp_cnt[i] <= rsp_cnt[i] + 1;
      end
    end
    if (rsp_valid != '0) tot_rsp <= tot_rsp + 1;
    if (div_start && !ds_prev) starts <= starts + 1;
    rr_prev <= req_ready;
    rv_prev <= rsp_valid;
    ds_prev <= div_start;
  end

  task automatic run_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                        output int lat);
    bit seen;
    int t_acc;
    q = '0;
    r = '0;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_valid[i] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (req_ready[i]) seen = 1'b1;
    end
    check_eq("accept_seen", 32'(seen), 1);
    t_acc = cyc;
    req_valid[i] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid[i]) begin
        seen = 1'b1;
        q = rsp_quot;
        r = rsp_rem;
      end
    end
    check_eq("rsp_seen", 32'(seen), 1);
    lat = cyc - t_acc;
  endtask

  initial begin
    logic [WIDTH-1:0] q, r;
    logic [WIDTH-1:0] exp_q [NREQ];
    logic [WIDTH-1:0] exp_r [NREQ];
    int               lat, s0, tr, rdy_cyc, acc_cyc, g;
    bit               seen, bad;

    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_ready", 32'(req_ready), 0);
    check_eq("rst_rsp", 32'(rsp_valid), 0);
    check_eq("rst_start", 32'(div_start), 0);
    check_eq("rst_div_ab", 32'({div_a, div_b}), 0);
    check_eq("rst_rsp_qr", 32'({rsp_quot, rsp_rem}), 0);
    rst_n = 1'b1;

    // Single operation 13/4
    s0 = starts;
    run_op(0, 4'd13, 4'd4, q, r, lat);
    check_eq("t1_quot", 32'(q), 3);
    check_eq("t1_rem", 32'(r), 1);
    check_eq("t1_latency", 32'(lat), 3 + DivLat);
    @(negedge clk);
    check_eq("t1_starts", 32'(starts - s0), 1);
    check_eq("t1_hold_quot", 32'(rsp_quot), 3);

    // Contention from reset: both held valid, grants alternate 0,1,0,1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_a = {4'd9, 4'd15};
    req_b = {4'd3, 4'd2};
    exp_q[0] = 4'd7; exp_r[0] = 4'd1;
    exp_q[1] = 4'd3; exp_r[1] = 4'd0;
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      g = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
        @(negedge clk);
        if (req_ready != '0) begin
          seen = 1'b1;
          g = req_ready[1] ? 1 : 0;
        end
      end
      check_eq("t2_accept_seen", 32'(seen), 1);
      check_eq("t2_grant", 32'(g), 32'(n % 2));
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
        @(negedge clk);
        if (rsp_valid != '0) begin
          seen = 1'b1;
          check_eq("t2_rsp_owner", 32'(rsp_valid), 32'(1 << g));
          check_eq("t2_quot", 32'(rsp_quot), 32'(exp_q[g]));
          check_eq("t2_rem", 32'(rsp_rem), 32'(exp_r[g]));
        end
      end
      check_eq("t2_rsp_seen", 32'(seen), 1);
    end
    req_valid = '0;
    repeat (2) @(negedge clk);

    // Divide by zero
    s0 = starts;
    run_op(0, 4'd9, 4'd0, q, r, lat);
    check_eq("t3_quot", 32'(q), 15);
    check_eq("t3_rem", 32'(r), 9);
    @(negedge clk);
`ifdef DIV_ARB_ZERO_BYPASS_EN
    check_eq("t3_latency", 32'(lat), 1);
    check_eq("t3_starts", 32'(starts - s0), 0);
`else
    check_eq("t3_latency", 32'(lat), 3 + DivLat);
    check_eq("t3_starts", 32'(starts - s0), 1);
`endif

    // Reset while waiting on the divider
    req_a[3:0] = 4'd7;
    req_b[3:0] = 4'd2;
    req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (req_ready[0]) seen = 1'b1;
    end
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (busy && !div_start && !div_ready) seen = 1'b1;
    end
    check_eq("t4_wait_reached", 32'(seen), 1);
    tr = tot_rsp;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t4_busy", 32'(busy), 0);
    check_eq("t4_rsp", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    req_a[3:0] = 4'd8;
    req_b[3:0] = 4'd3;
    req_valid[0] = 1'b1;
    rdy_cyc = -1;
    acc_cyc = -1;
    for (int k = 0; k < 100 && acc_cyc < 0; k++) begin
      @(negedge clk);
      if (req_ready[0]) acc_cyc = cyc;
      else if (div_ready && rdy_cyc < 0) rdy_cyc = cyc;
    end
    req_valid[0] = 1'b0;
    check_eq("t4_issue_after_ready", 32'(rdy_cyc >= 0 && acc_cyc > rdy_cyc), 1);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        seen = 1'b1;
        check_eq("t4_quot", 32'(rsp_quot), 2);
        check_eq("t4_rem", 32'(rsp_rem), 2);
      end
    end
    @(negedge clk);
    check_eq("t4_rsp_count", 32'(tot_rsp - tr), 1);

    // Divider back-pressure
    hold_low = 1'b1;
    req_a[3:0] = 4'd6;
    req_b[3:0] = 4'd2;
    req_valid[0] = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if ((req_ready != '0) || div_start || busy) bad = 1'b1;
    end
    check_eq("t5_stall", 32'(bad), 0);
    hold_low = 1'b0;
    run_op(0, 4'd6, 4'd2, q, r, lat);
    check_eq("t5_quot", 32'(q), 3);
    check_eq("t5_rem", 32'(r), 0);

    // Requester 1 alone
    run_op(1, 4'd14, 4'd5, q, r, lat);
    check_eq("t6_quot", 32'(q), 2);
    check_eq("t6_rem", 32'(r), 4);
    check_eq("t6_latency", 32'(lat), 3 + DivLat);

    repeat (3) @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      check_eq("acc_vs_rsp", 32'(rsp_cnt[i]), 32'(acc_cnt[i]));
    end
    check_eq("final_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
